// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter and transfer sequencer for the shared internal bus.
// One grant per cycle; drives the bus source select and one destination load strobe.
module bus_transfer_arbiter #(
  parameter int N_REQ    = 3,
  parameter int N_SRC    = 24,
  parameter int N_DST    = 24,
  parameter int MAX_LOCK = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [5*N_REQ-1:0] src_sel,
  input  logic [5*N_REQ-1:0] dst_sel,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   err,
  output logic [4:0]         bus_select,
  output logic [31:0]        dst_load,
  output logic               bus_busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   owner, owner_d;
  logic [IW-1:0]   ptr, ptr_d;
  logic [CW-1:0]   lock_cnt, lock_cnt_d;

  logic            arb_found;
  logic [IW-1:0]   arb_idx;
  logic            others_pending;
  logic            cont;
  logic            grant;
  logic [IW-1:0]   winner;
  logic [4:0]      src_w, dst_w;

  logic [N_REQ-1:0] gnt_d, ack_d, err_d;
  logic [4:0]       bus_select_d;
  logic [31:0]      dst_load_d;
  logic             bus_busy_d;

  // Rotating priority: search starts just after the last winner.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!arb_found && req[(int'(ptr) + i) % N_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = IW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  // A locked owner keeps the bus until the cap, and past it only if nobody else
  // is waiting. A rejected transfer never continues a lock.
  assign others_pending = |(req & ~(N_REQ'(1) << owner));
  assign cont = (state == XFER) && (err == '0) && lock[owner] && req[owner] &&
                ((lock_cnt < CW'(MAX_LOCK)) || !others_pending);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = IDLE;
    owner_d      = owner;
    ptr_d        = ptr;
    lock_cnt_d   = '0;
    grant        = 1'b0;
    winner       = '0;
    src_w        = '0;
    dst_w        = '0;
    gnt_d        = '0;
    ack_d        = '0;
    err_d        = '0;
    bus_select_d = '0;
    dst_load_d   = '0;
    bus_busy_d   = 1'b0;

    if (cont) begin
      grant      = 1'b1;
      winner     = owner;
      lock_cnt_d = (lock_cnt < CW'(MAX_LOCK)) ? lock_cnt + CW'(1) : lock_cnt;
    end else if (arb_found) begin
      grant      = 1'b1;
      winner     = arb_idx;
      lock_cnt_d = CW'(1);
    end

    if (grant) begin
      state_d    = XFER;
      owner_d    = winner;
      ptr_d      = winner;
      src_w      = src_sel[5*int'(winner) +: 5];
      dst_w      = dst_sel[5*int'(winner) +: 5];
      gnt_d      = N_REQ'(1) << winner;
      bus_busy_d = 1'b1;
      if ((int'(src_w) < N_SRC) && (int'(dst_w) < N_DST)) begin
        ack_d        = N_REQ'(1) << winner;
        bus_select_d = src_w;
        dst_load_d   = 32'h1 << dst_w;
      end else begin
        err_d = N_REQ'(1) << winner;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= IW'(N_REQ - 1);
      lock_cnt   <= '0;
      gnt        <= '0;
      ack        <= '0;
      err        <= '0;
      bus_select <= '0;
      dst_load   <= '0;
      bus_busy   <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      ptr        <= ptr_d;
      lock_cnt   <= lock_cnt_d;
      gnt        <= gnt_d;
      ack        <= ack_d;
      err        <= err_d;
      bus_select <= bus_select_d;
      dst_load   <= dst_load_d;
      bus_busy   <= bus_busy_d;
    end
  end

endmodule
